// File: rtl/sram2rw_param.sv
// sram2rw_param: two-port read/write SRAM with per-lane write masks,
// selectable read latency (1 or 2 edges), selectable read-during-write
// behaviour, same-address write collision flag and a sequential
// memory-clear engine. The array itself is never reset.
//
// Request qualification: a port request is accepted on a posedge of CE
// when its chip select is low and the block is not busy clearing; there
// is no back-pressure, so an accepted read always produces data exactly
// RD_LAT edges later and an accepted write always lands on that edge.
module sram2rw_param #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LANE    = 8,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NL = WIDTH / LANE
) (
  input  logic             CE,
  input  logic             RSTB,
  input  logic             CSB1,
  input  logic             CSB2,
  input  logic             WEB1,
  input  logic             WEB2,
  input  logic             OEB1,
  input  logic             OEB2,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic [NL-1:0]    BWEB1,
  input  logic [NL-1:0]    BWEB2,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  input  logic             CLRB,
  output logic             BUSY,
  output logic             COLL
);

  // Clear engine states; the current state is visible through BUSY.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    clr_cnt_q;
  logic [AW-1:0]    clr_cnt_d;
  logic             busy;

  logic             a1_ok;
  logic             a2_ok;
  logic             rd1;
  logic             rd2;
  logic             wr1;
  logic             wr2;
  logic             coll_d;
  logic             coll_q;

  logic [WIDTH-1:0] old1;
  logic [WIDTH-1:0] old2;
  logic [WIDTH-1:0] new1;
  logic [WIDTH-1:0] new2;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;

  logic [WIDTH-1:0] o1_q;
  logic [WIDTH-1:0] o2_q;

  assign busy = (state_q == CLEAR);
  assign BUSY = busy;
  assign COLL = coll_q;
  assign O1   = o1_q;
  assign O2   = o2_q;

  // Overlay the enabled lanes of both ports onto a stored word. Port 1 is
  // applied last so it wins on lanes both ports enable.
  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old,
                                                  input logic hit1,
                                                  input logic hit2);
    logic [WIDTH-1:0] w;
    w = old;
    for (int k = 0; k < NL; k++) begin
      if (hit2 && !BWEB2[k]) w[k*LANE +: LANE] = I2[k*LANE +: LANE];
      if (hit1 && !BWEB1[k]) w[k*LANE +: LANE] = I1[k*LANE +: LANE];
    end
    return w;
  endfunction

  // Request decode: out-of-range addresses never write and read as zero.
  always_comb begin
    a1_ok  = ({1'b0, A1} < (AW+1)'(DEPTH));
    a2_ok  = ({1'b0, A2} < (AW+1)'(DEPTH));
    rd1    = !CSB1 && !OEB1 && !busy;
    rd2    = !CSB2 && !OEB2 && !busy;
    wr1    = !CSB1 && !WEB1 && !busy && a1_ok;
    wr2    = !CSB2 && !WEB2 && !busy && a2_ok;
    coll_d = wr1 && wr2 && (A1 == A2);
  end

  // Pre-edge words, post-edge merged words and the word each read returns.
  always_comb begin
    old1   = a1_ok ? mem[A1] : '0;
    old2   = a2_ok ? mem[A2] : '0;
    new1   = merge_word(old1, wr1, wr2 && (A2 == A1));
    new2   = merge_word(old2, wr1 && (A1 == A2), wr2);
    rdata1 = '0;
    rdata2 = '0;
    if (a1_ok) rdata1 = (WR_MODE == 1) ? new1 : old1;
    if (a2_ok) rdata2 = (WR_MODE == 1) ? new2 : old2;
  end

  // Array update: clear engine owns the array while busy, otherwise the
  // ports write their merged words (identical when addresses coincide).
  always_ff @(posedge CE) begin
    if (busy) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr2) mem[A2] <= new2;
      if (wr1) mem[A1] <= new1;
    end
  end

  // Clear engine next-state: walk every address once, then return to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        clr_cnt_d = '0;
        if (!CLRB) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Clear engine state and collision flag registers.
  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      coll_q    <= coll_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             v1_q;
      logic             v2_q;
      logic [WIDTH-1:0] d1_q;
      logic [WIDTH-1:0] d2_q;

      // Two-stage read pipe: output stage loads only on a delayed valid.
      always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
          v1_q <= 1'b0;
          v2_q <= 1'b0;
          d1_q <= '0;
          d2_q <= '0;
          o1_q <= '0;
          o2_q <= '0;
        end else begin
          v1_q <= rd1;
          v2_q <= rd2;
          if (rd1)  d1_q <= rdata1;
          if (rd2)  d2_q <= rdata2;
          if (v1_q) o1_q <= d1_q;
          if (v2_q) o2_q <= d2_q;
        end
      end
    end else begin : g_lat1
      // Single-stage read: output loads on the read edge, holds otherwise.
      always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
          o1_q <= '0;
          o2_q <= '0;
        end else begin
          if (rd1) o1_q <= rdata1;
          if (rd2) o2_q <= rdata2;
        end
      end
    end
  endgenerate

endmodule
